// File: rtl/arbitro_mux9.sv
// Round-robin arbiter sharing the five-input mux9 selector between five requesters.
// Registered one-hot grant and select code, with a bounded hold time under contention.
module arbitro_mux9 #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        requisicao,
  output logic [4:0]        concessao,
  output logic [2:0]        controle,
  output logic              valido,
  output logic [HOLD_W-1:0] contagem
);

  typedef enum logic {OCIOSO, CONCEDIDO} estado_t;

  localparam logic [HOLD_W-1:0] LIMITE = HOLD_W'(MAX_HOLD - 1);

  estado_t           estado, estado_nx;
  logic [2:0]        dono, dono_nx;
  logic [2:0]        ultimo, ultimo_nx;
  logic [4:0]        concessao_nx;
  logic [2:0]        controle_nx;
  logic              valido_nx;
  logic [HOLD_W-1:0] contagem_nx;

  logic [4:0] outros;
  logic [2:0] vencedor_livre, vencedor_outros;
  logic [2:0] alvo;
  logic       trocar;

  // First set bit scanning from base+1 upward, wrapping 4 -> 0.
  function automatic logic [2:0] proximo(input logic [4:0] pedidos, input logic [2:0] base);
    logic [2:0] idx;
    logic       achou;
    proximo = 3'd0;
    achou   = 1'b0;
    idx     = base;
    for (int i = 0; i < 5; i++) begin
      idx = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      if (!achou && pedidos[idx]) begin
        proximo = idx;
        achou   = 1'b1;
      end
    end
  endfunction

  assign outros          = requisicao & ~(5'b00001 << dono);
  assign vencedor_livre  = proximo(requisicao, ultimo);
  assign vencedor_outros = proximo(outros, ultimo);

  always_comb begin
    estado_nx    = estado;
    dono_nx      = dono;
    ultimo_nx    = ultimo;
    concessao_nx = concessao;
    controle_nx  = controle;
    valido_nx    = valido;
    contagem_nx  = contagem;
    trocar       = 1'b0;
    alvo         = 3'd0;

    case (estado)
      OCIOSO: begin
        if (|requisicao) begin
          trocar = 1'b1;
          alvo   = vencedor_livre;
        end
      end
      CONCEDIDO: begin
        if (!requisicao[dono]) begin
          if (|outros) begin
            trocar = 1'b1;
            alvo   = vencedor_outros;
          end else begin
            estado_nx    = OCIOSO;
            concessao_nx = 5'b00000;
            valido_nx    = 1'b0;
            contagem_nx  = '0;
          end
        end else if ((contagem == LIMITE) && (|outros)) begin
          trocar = 1'b1;
          alvo   = vencedor_outros;
        end else if (contagem != LIMITE) begin
          contagem_nx = contagem + 1'b1;
        end
      end
      default: begin
        estado_nx    = OCIOSO;
        concessao_nx = 5'b00000;
        valido_nx    = 1'b0;
      end
    endcase

    // controle is left untouched when going idle so the mux output stays stable.
    if (trocar) begin
      estado_nx    = CONCEDIDO;
      dono_nx      = alvo;
      ultimo_nx    = alvo;
      concessao_nx = 5'b00001 << alvo;
      controle_nx  = alvo;
      valido_nx    = 1'b1;
      contagem_nx  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= OCIOSO;
      dono      <= 3'd4;
      ultimo    <= 3'd4;
      concessao <= 5'b00000;
      controle  <= 3'b000;
      valido    <= 1'b0;
      contagem  <= '0;
    end else begin
      estado    <= estado_nx;
      dono      <= dono_nx;
      ultimo    <= ultimo_nx;
      concessao <= concessao_nx;
      controle  <= controle_nx;
      valido    <= valido_nx;
      contagem  <= contagem_nx;
    end
  end

endmodule

// File: tb/tb_arbitro_mux9.sv
// Directed bench for arbitro_mux9: reset, latency, preemption, saturation,
// round-robin wrap, bubble-free handoff, async reset mid-grant and output invariants.
module tb_arbitro_mux9;

  logic       clock;
  logic       reset;
  logic [4:0] requisicao;
  logic [4:0] concessao;
  logic [2:0] controle;
  logic       valido;
  logic [3:0] contagem;

  int tests_run    = 0;
  int tests_failed = 0;

  arbitro_mux9 #(.MAX_HOLD(8), .HOLD_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .requisicao (requisicao),
    .concessao  (concessao),
    .controle   (controle),
    .valido     (valido),
    .contagem   (contagem)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [4:0] exp_conc, input logic [2:0] exp_ctrl,
                       input logic exp_val, input logic [3:0] exp_cnt);
    tests_run++;
    assert (concessao === exp_conc) else begin
      tests_failed++;
      $error("[TB] FAIL %s concessao: observed %b expected %b", tag, concessao, exp_conc);
    end
    tests_run++;
    assert (controle === exp_ctrl) else begin
      tests_failed++;
      $error("[TB] FAIL %s controle: observed %b expected %b", tag, controle, exp_ctrl);
    end
    tests_run++;
    assert (valido === exp_val) else begin
      tests_failed++;
      $error("[TB] FAIL %s valido: observed %b expected %b", tag, valido, exp_val);
    end
    tests_run++;
    assert (contagem === exp_cnt) else begin
      tests_failed++;
      $error("[TB] FAIL %s contagem: observed %0d expected %0d", tag, contagem, exp_cnt);
    end
  endtask

  // Structural invariants sampled away from the active edge.
  always @(negedge clock) begin
    tests_run++;
    assert ((valido === |concessao) && $onehot0(concessao) && (controle <= 3'd4) &&
            (!valido || (concessao === (5'b00001 << controle)))) else begin
      tests_failed++;
      $error("[TB] FAIL invariant: observed conc=%b ctrl=%b val=%b expected consistent one-hot grant",
             concessao, controle, valido);
    end
  end

  initial begin
    reset      = 1'b1;
    requisicao = 5'b11111;
    #2 reset = 1'b0;
    #1 check("reset_async", 5'b00000, 3'b000, 1'b0, 4'd0);
    step();
    step();
    check("reset_held", 5'b00000, 3'b000, 1'b0, 4'd0);

    reset = 1'b1;
    step();
    check("first_grant", 5'b00001, 3'b000, 1'b1, 4'd0);

    requisicao = 5'b00000;
    step();
    check("go_idle", 5'b00000, 3'b000, 1'b0, 4'd0);

    requisicao = 5'b00100;
    step();
    check("single_latency", 5'b00100, 3'b010, 1'b1, 4'd0);
    requisicao = 5'b00000;
    step();
    check("single_drop", 5'b00000, 3'b010, 1'b0, 4'd0);

    requisicao = 5'b00010;
    step();
    check("preempt_grant1", 5'b00010, 3'b001, 1'b1, 4'd0);
    requisicao = 5'b01010;
    for (int c = 1; c <= 7; c++) begin
      step();
      check("preempt_hold", 5'b00010, 3'b001, 1'b1, 4'(c));
    end
    step();
    check("preempt_move", 5'b01000, 3'b011, 1'b1, 4'd0);

    requisicao = 5'b00010;
    step();
    check("release_to1", 5'b00010, 3'b001, 1'b1, 4'd0);
    for (int k = 1; k <= 22; k++) begin
      step();
      check("saturate", 5'b00010, 3'b001, 1'b1, (k < 7) ? 4'(k) : 4'd7);
    end

    requisicao = 5'b01000;
    step();
    check("setup_owner3", 5'b01000, 3'b011, 1'b1, 4'd0);

    requisicao = 5'b10001;
    for (int g = 0; g < 4; g++) begin
      step();
      if (g % 2 == 0) check("rr_wrap", 5'b10000, 3'b100, 1'b1, 4'd0);
      else            check("rr_wrap", 5'b00001, 3'b000, 1'b1, 4'd0);
      for (int c = 1; c <= 7; c++) begin
        step();
        if (g % 2 == 0) check("rr_hold", 5'b10000, 3'b100, 1'b1, 4'(c));
        else            check("rr_hold", 5'b00001, 3'b000, 1'b1, 4'(c));
      end
    end

    requisicao = 5'b00100;
    step();
    check("handoff_owner2", 5'b00100, 3'b010, 1'b1, 4'd0);
    requisicao = 5'b10100;
    step();
    check("handoff_pending", 5'b00100, 3'b010, 1'b1, 4'd1);
    requisicao = 5'b10000;
    step();
    check("handoff_nobubble", 5'b10000, 3'b100, 1'b1, 4'd0);

    requisicao = 5'b01000;
    step();
    check("midreset_owner3", 5'b01000, 3'b011, 1'b1, 4'd0);
    for (int c = 1; c <= 5; c++) step();
    check("midreset_cnt5", 5'b01000, 3'b011, 1'b1, 4'd5);
    #3 reset = 1'b0;
    #1 check("midreset_async", 5'b00000, 3'b000, 1'b0, 4'd0);
    #2 reset = 1'b1;
    step();
    check("midreset_regrant", 5'b01000, 3'b011, 1'b1, 4'd0);

    requisicao = 5'b00111;
    step();
    check("simul_rr0", 5'b00001, 3'b000, 1'b1, 4'd0);
    requisicao = 5'b00110;
    step();
    check("simul_rr1", 5'b00010, 3'b001, 1'b1, 4'd0);
    requisicao = 5'b00000;
    step();
    check("final_idle", 5'b00000, 3'b001, 1'b0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
